siso_mux8_sched: RTL and testbench

Round-robin scheduler that shares one serial output between eight serial-in lanes. It drives the 3-bit select of the 8:1 mux tree built from `sg13g2_mux2_1` cells. It grants one requesting lane for a programmable frame of bit-times, then rotates to the next requester. Between the mux tree's select inputs and the downstream serial sink, it also supplies a one-cycle select-settle guard, a valid qualifier and an end-of-frame marker.

---
 rtl/siso_mux8_sched.sv | 115 +++++++++++
 tb/tb_siso_mux8_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/siso_mux8_sched.sv
// Round-robin scheduler sharing one serial output among eight lanes via an 8:1 mux tree.
// Define SISO_MUX8_SETTLE_EN to insert a one-cycle select-settle guard before every frame.
module siso_mux8_sched #(
   parameter int unsigned FRAME_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [7:0]         req,
   input  logic [FRAME_W-1:0] frame_len,
   output logic [2:0]         sel,
   output logic [7:0]         grant,
   output logic               valid,
   output logic               last,
   output logic               busy
);

   localparam int unsigned CntW = FRAME_W + 1;

   typedef enum logic [1:0] {StIdle, StSettle, StXfer} state_e;

   state_e          state_q;
   logic [2:0]      ptr_q;
   logic [CntW-1:0] cnt_q;

   logic            arb_pt;
   logic            found;
   logic [2:0]      base;
   logic [2:0]      idx;
   logic [2:0]      win;
   logic [CntW-1:0] len_load;

   // A zero length field stands for the full 2^FRAME_W bits.
   assign len_load = (frame_len == '0) ? (CntW'(1) << FRAME_W) : CntW'(frame_len);

   // On the final XFER bit the current select is the lane just served, so search from it.
   assign arb_pt = (state_q == StIdle) || ((state_q == StXfer) && last);
   assign base   = (state_q == StXfer) ? sel : ptr_q;

   always_comb begin
      found = 1'b0;
      win   = base;
      idx   = base;
      for (int k = 1; k <= 8; k++) begin
         idx = base + 3'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= 3'd7;
         cnt_q   <= '0;
         sel     <= 3'd0;
         grant   <= 8'd0;
         valid   <= 1'b0;
         last    <= 1'b0;
         busy    <= 1'b0;
      end else if (arb_pt) begin
         if (state_q == StXfer) begin
            ptr_q <= sel;
         end
         if (en && found) begin
            sel   <= win;
            grant <= 8'd1 << win;
            cnt_q <= len_load;
            busy  <= 1'b1;
`ifdef SISO_MUX8_SETTLE_EN
            state_q <= StSettle;
            valid   <= 1'b0;
            last    <= 1'b0;
`else
            state_q <= StXfer;
            valid   <= 1'b1;
            last    <= (len_load == CntW'(1));
`endif
         end else begin
            // Select is held on the way to idle so the mux tree does not toggle.
            state_q <= StIdle;
            cnt_q   <= '0;
            grant   <= 8'd0;
            valid   <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
         end
      end else begin
         unique case (state_q)
`ifdef SISO_MUX8_SETTLE_EN
            StSettle: begin
               state_q <= StXfer;
               valid   <= 1'b1;
               last    <= (cnt_q == CntW'(1));
            end
`endif
            StXfer: begin
               cnt_q <= cnt_q - CntW'(1);
               valid <= 1'b1;
               last  <= (cnt_q == CntW'(2));
            end
            default: begin
               state_q <= StIdle;
               valid   <= 1'b0;
               last    <= 1'b0;
               busy    <= 1'b0;
               grant   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_siso_mux8_sched.sv
// Bench for siso_mux8_sched: frame-level queue model checked every cycle plus directed literals.
// Follows SISO_MUX8_SETTLE_EN the same way the design does.
module tb_siso_mux8_sched;

   localparam int unsigned FW = 4;
`ifdef SISO_MUX8_SETTLE_EN
   localparam bit SETTLE = 1'b1;
`else
   localparam bit SETTLE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic [7:0]    req = 8'h00;
   logic [FW-1:0] frame_len = '0;
   logic [2:0]    sel;
   logic [7:0]    grant;
   logic          valid, last, busy;

   int checks = 0;
   int failures = 0;

   siso_mux8_sched #(.FRAME_W(FW)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .frame_len(frame_len),
      .sel(sel), .grant(grant), .valid(valid), .last(last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       valid;
      logic       last;
      logic [2:0] sel;
      logic [7:0] grant;
   } exp_t;

   function automatic exp_t mk(logic b, logic v, logic l, int s, logic [7:0] g);
      exp_t e;
      e.busy = b; e.valid = v; e.last = l; e.sel = 3'(s); e.grant = g;
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
      end
   endtask

   // Model: each grant expands into a list of per-cycle expected outputs.
   exp_t cur = '0;
   exp_t exp_q[$];
   int   last_lane = 7;
   int   win, len, lane;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         exp_q.delete();
         cur = '0;
         last_lane = 7;
      end else if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
      end else if (en && req != 8'h00) begin
         win = -1;
         for (int k = 1; k <= 8; k++) begin
            lane = (last_lane + k) % 8;
            if (win < 0 && req[lane]) win = lane;
         end
         last_lane = win;
         len = (frame_len == 0) ? (1 << FW) : int'(frame_len);
         if (SETTLE) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, win, 8'd1 << win));
         for (int i = 1; i <= len; i++)
            exp_q.push_back(mk(1'b1, 1'b1, i == len, win, 8'd1 << win));
         cur = exp_q.pop_front();
      end else begin
         cur = mk(1'b0, 1'b0, 1'b0, int'(cur.sel), 8'h00);
      end
   end

   // Per-cycle compare plus a frame monitor logging lane and length of each DUT frame.
   int   lanes[$];
   int   lens[$];
   int   bits = 0;
   logic pv = 1'b0, pl = 1'b0;

   initial forever begin
      @(negedge clk);
      check("outputs", 32'({busy, valid, last, sel, grant}), 32'(cur));
      if (rst) begin
         pv = 1'b0; pl = 1'b0; bits = 0;
      end else begin
         if (valid && (!pv || pl)) begin
            lanes.push_back(int'(sel));
            bits = 1;
         end else if (valid) begin
            bits++;
         end
         if (valid && last) lens.push_back(bits);
         pv = valid; pl = last;
      end
   end

   function automatic int lane_at(int i);
      return (i < lanes.size()) ? lanes[i] : -1;
   endfunction

   function automatic int len_at(int i);
      return (i < lens.size()) ? lens[i] : -1;
   endfunction

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      lanes.delete();
      lens.delete();
   endtask

   task automatic wait_bits(int n, int nframes);
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         step(1);
         #1;
         if (valid && bits == n && lens.size() == nframes) ok = 1'b1;
      end
      check("wait_bits", 32'(ok), 32'd1);
   endtask

   initial begin
      #1 rst = 1'b1;
      step(1);
      rst = 1'b0;

      // Reset and idle with no requests.
      en = 1'b1; req = 8'h00;
      rst_pulse();
      step(20);
      check("idle_outputs", 32'({busy, valid, last, grant}), 32'd0);
      check("idle_sel", 32'(sel), 32'd0);

      // Single lane re-wins.
      req = 8'h20; frame_len = 4'd3;
      step(3);
      check("single_grant", 32'(grant), 32'h20);
      step(10);
      req = 8'h00; en = 1'b0;
      step(8);
      check("single_lane0", 32'(lane_at(0)), 32'd5);
      check("single_len0", 32'(len_at(0)), 32'd3);
      check("single_lane1", 32'(lane_at(1)), 32'd5);
      check("single_len1", 32'(len_at(1)), 32'd3);

      // Rotation over lanes 0, 4, 7.
      rst_pulse();
      en = 1'b1; req = 8'h91; frame_len = 4'd2;
      step(18);
      req = 8'h00; en = 1'b0;
      step(8);
      check("rot_lane0", 32'(lane_at(0)), 32'd0);
      check("rot_lane1", 32'(lane_at(1)), 32'd4);
      check("rot_lane2", 32'(lane_at(2)), 32'd7);
      check("rot_lane3", 32'(lane_at(3)), 32'd0);
      check("rot_lane4", 32'(lane_at(4)), 32'd4);
      check("rot_len4", 32'(len_at(4)), 32'd2);

      // Zero length field means 16 bits; later frame_len changes are ignored.
      rst_pulse();
      en = 1'b1; req = 8'h01; frame_len = 4'd0;
      step(3);
      frame_len = 4'd7;
      step(3);
      en = 1'b0; req = 8'h00;
      step(20);
      check("enc_frames", 32'(lens.size()), 32'd1);
      check("enc_len", 32'(len_at(0)), 32'd16);

      // Request and enable drop at bit 2 of 5.
      rst_pulse();
      en = 1'b1; req = 8'h08; frame_len = 4'd5;
      wait_bits(2, 0);
      req = 8'h00; en = 1'b0;
      step(12);
      check("drop_frames", 32'(lens.size()), 32'd1);
      check("drop_len", 32'(len_at(0)), 32'd5);
      check("drop_grant", 32'(grant), 32'd0);
      check("drop_sel", 32'(sel), 32'd3);
      check("drop_busy", 32'(busy), 32'd0);

      // Reset mid-frame after lane 0 was served: lane 0 is again first.
      rst_pulse();
      en = 1'b1; req = 8'h01; frame_len = 4'd5;
      wait_bits(2, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_outputs", 32'({busy, valid, last, sel, grant}), 32'd0);
      rst = 1'b0;
      lanes.delete();
      lens.delete();
      req = 8'h03;
      step(10);
      check("rst_first_lane", 32'(lane_at(0)), 32'd0);
      req = 8'h00; en = 1'b0;
      step(8);

      // Two lanes alternating with one-bit frames.
      rst_pulse();
      en = 1'b1; req = 8'h03; frame_len = 4'd1;
      step(10);
      req = 8'h00; en = 1'b0;
      step(5);
      check("alt_lane0", 32'(lane_at(0)), 32'd0);
      check("alt_lane1", 32'(lane_at(1)), 32'd1);
      check("alt_lane2", 32'(lane_at(2)), 32'd0);
      check("alt_lane3", 32'(lane_at(3)), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
